// File: rtl/uart_esc_decoder.sv
// uart_esc_decoder: strips the ESC protocol from the UART RX FIFO stream into data, command and pulse outputs
// Ports: CLK_I/RST_I clock and async reset; RX_EMPTY_I/DREC_I/RE_O FWFT RX FIFO pop side;
// DATA_O/VALID_O/READY_I decoded data handshake; CMD_O/CMD_VALID_O command byte and strobe;
// ESC_DETECTED_O completed-escape pulse; ERR_O escape-prefix timeout pulse.
module uart_esc_decoder #(
  parameter logic [7:0] ESC_BYTE       = 8'hB1,
  parameter int         TIMEOUT_CYCLES = 1000
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       RX_EMPTY_I,
  input  logic [7:0] DREC_I,
  output logic       RE_O,
  output logic [7:0] DATA_O,
  output logic       VALID_O,
  input  logic       READY_I,
  output logic [7:0] CMD_O,
  output logic       CMD_VALID_O,
  output logic       ESC_DETECTED_O,
  output logic       ERR_O
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);
  typedef enum logic {NORMAL, ESC_SEEN} state_t;
  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [7:0]    r_data, w_data_nxt, r_cmd, w_cmd_nxt;
  logic          r_valid, w_valid_nxt, r_cmd_vld, w_cmd_vld_nxt;
  logic          r_esc, w_esc_nxt, r_err, w_err_nxt;
  logic          w_free, w_pop, w_is_esc;
  assign w_free    = !r_valid || READY_I;
  assign w_pop     = !RST_I && !RX_EMPTY_I && w_free;
  assign w_is_esc  = DREC_I == ESC_BYTE;
  assign w_cnt_inc = (r_cnt == TMO) ? r_cnt : r_cnt + CW'(1);
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_data_nxt    = r_data;
    w_valid_nxt   = r_valid && !READY_I;
    w_cmd_nxt     = r_cmd;
    w_cmd_vld_nxt = 1'b0;
    w_esc_nxt     = 1'b0;
    w_err_nxt     = 1'b0;
    if (r_state == NORMAL) begin
      if (w_pop && w_is_esc) begin
        w_state_nxt = ESC_SEEN;
        w_cnt_nxt   = '0;
      end else if (w_pop) begin
        w_data_nxt  = DREC_I;
        w_valid_nxt = 1'b1;
      end
    end else if (w_pop) begin
      // a byte arriving on the terminal-count cycle still completes the escape
      w_state_nxt   = NORMAL;
      w_esc_nxt     = 1'b1;
      w_data_nxt    = w_is_esc ? DREC_I : r_data;
      w_valid_nxt   = w_is_esc || w_valid_nxt;
      w_cmd_nxt     = w_is_esc ? r_cmd : DREC_I;
      w_cmd_vld_nxt = !w_is_esc;
    end else if (w_cnt_inc == TMO) begin
      w_state_nxt = NORMAL;
      w_cnt_nxt   = '0;
      w_err_nxt   = 1'b1;
    end else begin
      w_cnt_nxt = w_cnt_inc;
    end
  end
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_state   <= NORMAL;
      r_cnt     <= '0;
      r_data    <= 8'h00;
      r_valid   <= 1'b0;
      r_cmd     <= 8'h00;
      r_cmd_vld <= 1'b0;
      r_esc     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_data    <= w_data_nxt;
      r_valid   <= w_valid_nxt;
      r_cmd     <= w_cmd_nxt;
      r_cmd_vld <= w_cmd_vld_nxt;
      r_esc     <= w_esc_nxt;
      r_err     <= w_err_nxt;
    end
  end
  assign RE_O           = w_pop;
  assign DATA_O         = r_data;
  assign VALID_O        = r_valid;
  assign CMD_O          = r_cmd;
  assign CMD_VALID_O    = r_cmd_vld;
  assign ESC_DETECTED_O = r_esc;
  assign ERR_O          = r_err;
endmodule

// File: tb/tb_uart_esc_decoder.sv
// tb_uart_esc_decoder: directed self-checking bench for uart_esc_decoder with a FWFT FIFO model
module tb_uart_esc_decoder;
  logic       clk = 1'b0, rst = 1'b1, rx_empty = 1'b1, ready = 1'b1;
  logic [7:0] drec = 8'h00;
  logic       re, valid, cmd_v, esc, err, pend;
  logic [7:0] data, cmd;
  logic [7:0] q[$];
  int n_chk = 0, n_err = 0;
  uart_esc_decoder #(.ESC_BYTE(8'hB1), .TIMEOUT_CYCLES(4)) dut (
    .CLK_I(clk), .RST_I(rst), .RX_EMPTY_I(rx_empty), .DREC_I(drec), .RE_O(re),
    .DATA_O(data), .VALID_O(valid), .READY_I(ready), .CMD_O(cmd),
    .CMD_VALID_O(cmd_v), .ESC_DETECTED_O(esc), .ERR_O(err)
  );
  always #5 clk = ~clk;
  always begin
    @(negedge clk);
    #2 pend = re;
    @(posedge clk);
    #1 if (pend && q.size() > 0) void'(q.pop_front());
    rx_empty = q.size() == 0;
    drec = rx_empty ? 8'h00 : q[0];
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic outs(input string tag, input logic v, input logic [7:0] d, input logic cv, input logic e, input logic er);
    chk({tag, " valid"}, valid, v);
    if (v) chk({tag, " data"}, data, d);
    chk({tag, " cmd_valid"}, cmd_v, cv);
    chk({tag, " esc"}, esc, e);
    chk({tag, " err"}, err, er);
  endtask
  task automatic push(input logic [7:0] b);
    q.push_back(b);
    rx_empty = 1'b0;
    drec = q[0];
  endtask
  task automatic nxt();
    @(negedge clk);
  endtask
  initial begin
    nxt(); nxt();
    outs("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("reset data", data, 8'h00);
    chk("reset cmd", cmd, 8'h00);
    rst = 1'b0;
    push(8'h12); push(8'h34);
    nxt(); outs("plain1", 1'b1, 8'h12, 1'b0, 1'b0, 1'b0); chk("plain1 re", re, 1'b1);
    nxt(); outs("plain2", 1'b1, 8'h34, 1'b0, 1'b0, 1'b0); chk("plain2 re", re, 1'b0);
    nxt(); outs("plain3", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    push(8'hB1); push(8'hB1); push(8'h55);
    nxt(); outs("lit1", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    nxt(); outs("lit2", 1'b1, 8'hB1, 1'b0, 1'b1, 1'b0);
    nxt(); outs("lit3", 1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    nxt(); outs("lit4", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    push(8'hB1); push(8'h07); push(8'hAA);
    nxt(); outs("cmd1", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    nxt(); outs("cmd2", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0); chk("cmd2 cmd", cmd, 8'h07);
    nxt(); outs("cmd3", 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0); chk("cmd3 cmd", cmd, 8'h07);
    nxt(); outs("cmd4", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    push(8'h01); push(8'h02); push(8'h03); ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      nxt(); outs("bp_hold", 1'b1, 8'h01, 1'b0, 1'b0, 1'b0); chk("bp_hold re", re, 1'b0);
    end
    ready = 1'b1;
    nxt(); outs("bp2", 1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
    nxt(); outs("bp3", 1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
    nxt(); outs("bp4", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0); chk("bp fifo empty", rx_empty, 1'b1);
    push(8'hB1);
    for (int i = 0; i < 4; i++) begin
      nxt(); outs("tmo_wait", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    end
    nxt(); outs("tmo_err", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    nxt(); outs("tmo_after", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    push(8'h42);
    nxt(); outs("tmo_data", 1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
    nxt(); outs("tmo_idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    push(8'hB1);
    for (int i = 0; i < 4; i++) begin
      nxt(); outs("tc_wait", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    end
    push(8'h42);
    nxt(); outs("tc_cmd", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0); chk("tc_cmd cmd", cmd, 8'h42);
    nxt(); outs("tc_after", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    push(8'hB1);
    nxt(); outs("rst_esc", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    #3 rst = 1'b1;
    nxt(); push(8'h07);
    #1 outs("rst_hold", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("rst_hold re", re, 1'b0);
    chk("rst_hold data", data, 8'h00);
    chk("rst_hold cmd", cmd, 8'h00);
    rst = 1'b0;
    nxt(); outs("rst_data", 1'b1, 8'h07, 1'b0, 1'b0, 1'b0);
    nxt(); outs("rst_idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
